// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the decimating FIR datapath.
// FIR_DECIM_SAT_EN selects saturation instead of two's-complement wrap in sat_wrap().
package fir_pkg;

    typedef enum logic [1:0] {COLLECT, MAC, OUT} fir_decim_state_e;

    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

    // Brings a wide result into dw-bit signed range; the caller keeps the low dw bits.
    function automatic logic signed [63:0] sat_wrap(input logic signed [63:0] r, input int dw);
`ifdef FIR_DECIM_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (r > hi) return hi;
        if (r < lo) return lo;
        return r;
`else
        return (r <<< (64 - dw)) >>> (64 - dw);
`endif
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Single signed MAC: one registered product stage feeding an accumulator.
// clr zeroes the accumulator; en marks the current a*b as a valid term.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int A_W   = 5,
    parameter int B_W   = 5,
    parameter int ACC_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);
    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   prod_p1_q, prod_p1_d;
    logic                    vld_p1_q, vld_p1_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
        prod_p1_d = P_W'(a) * P_W'(b);
        vld_p1_d  = en && !clr;
        acc_d     = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (vld_p1_q) begin
            acc_d = acc_q + ACC_W'(prod_p1_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_p1_q <= '0;
            vld_p1_q  <= 1'b0;
            acc_q     <= '0;
        end else begin
            prod_p1_q <= prod_p1_d;
            vld_p1_q  <= vld_p1_d;
            acc_q     <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fir_decim_mac.sv
// Decimate-by-DECIM FIR: collects DECIM samples, runs a one-tap-per-cycle MAC, emits one output.
// Define FIR_DECIM_SAT_EN to saturate the output instead of wrapping it.
module fir_decim_mac
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH      = 5,
    parameter int TAP_COEFF_WIDTH = 5,
    parameter int NUM_TAPS        = 50,
    parameter int DECIM           = 2,
    parameter int OUT_SHIFT       = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [DATA_WIDTH-1:0]      in,
    input  logic signed [TAP_COEFF_WIDTH-1:0] tap_coeffs [NUM_TAPS],
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [DATA_WIDTH-1:0]      out
);
    localparam int AW = acc_width(DATA_WIDTH, TAP_COEFF_WIDTH, NUM_TAPS);
    localparam int KW = $clog2(NUM_TAPS + 2);
    localparam int TW = $clog2(NUM_TAPS);
    localparam int PW = $clog2(DECIM + 1);
    localparam logic [KW-1:0] K_END   = KW'(NUM_TAPS);
    localparam logic [KW-1:0] K_DONE  = KW'(NUM_TAPS + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);

    fir_decim_state_e                state_q, state_d;
    logic [PW-1:0]                   phase_q, phase_d;
    logic [KW-1:0]                   k_q, k_d;
    logic signed [DATA_WIDTH-1:0]    x_q [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0]    x_d [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0]    out_q, out_d;
    logic                            out_valid_q, out_valid_d;
    logic                            mac_en, mac_clr;
    logic [TW-1:0]                   tap_idx;
    logic signed [AW-1:0]            mac_acc;
    logic signed [63:0]              r_wide;

    fir_mac_unit #(
        .A_W   (DATA_WIDTH),
        .B_W   (TAP_COEFF_WIDTH),
        .ACC_W (AW)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (x_q[tap_idx]),
        .b   (tap_coeffs[tap_idx]),
        .acc (mac_acc)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        k_d         = k_q;
        x_d         = x_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        mac_en      = 1'b0;
        mac_clr     = 1'b0;
        tap_idx     = (k_q < K_END) ? TW'(k_q) : '0;
        r_wide      = 64'(mac_acc) >>> OUT_SHIFT;
        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    x_d[0] = in;
                    for (int i = 1; i < NUM_TAPS; i++) x_d[i] = x_q[i-1];
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        k_d     = '0;
                        mac_clr = 1'b1;
                        state_d = MAC;
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            MAC: begin
                // Issue taps 0..NUM_TAPS-1, then two cycles drain the product register and accumulator.
                mac_en = (k_q < K_END);
                if (k_q == K_DONE) begin
                    state_d     = OUT;
                    out_valid_d = 1'b1;
                    out_d       = DATA_WIDTH'(sat_wrap(r_wide, DATA_WIDTH));
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            phase_q     <= '0;
            k_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) x_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            k_q         <= k_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            x_q         <= x_d;
        end
    end

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule

// File: tb/tb_fir_decim_mac.sv
// Randomized and directed bench for fir_decim_mac against a plain-arithmetic convolution model.
module tb_fir_decim_mac;
    localparam int DW    = 5;
    localparam int CW    = 5;
    localparam int NT    = 50;
    localparam int DEC   = 2;
    localparam int SHIFT = 0;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in = '0;
    logic signed [CW-1:0] coef [NT];
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] out;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     acc_cyc = 0;
    int     nacc = 0;
    bit     busy = 1'b0;
    longint hist [$];
    longint exp_q [$];

    fir_decim_mac #(
        .DATA_WIDTH(DW), .TAP_COEFF_WIDTH(CW), .NUM_TAPS(NT), .DECIM(DEC), .OUT_SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in),
        .tap_coeffs(coef), .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Convolution of the full accepted history since reset, then shift and range reduction.
    function automatic longint model();
        longint s = 0;
        int n = hist.size();
        for (int k = 0; k < NT; k++)
            if (n - 1 - k >= 0) s += longint'(coef[k]) * hist[n-1-k];
        s = s >>> SHIFT;
`ifdef FIR_DECIM_SAT_EN
        if (s > 15) s = 15;
        if (s < -16) s = -16;
`else
        s = ((s % 32) + 32) % 32;
        if (s >= 16) s -= 32;
`endif
        return s;
    endfunction

    task automatic step(input logic v, input logic signed [DW-1:0] d, input logic ordy, output logic took);
        logic                 acc, hs, ov0;
        logic signed [DW-1:0] o0;
        longint               e;
        in_valid = v;
        in = d;
        out_ready = ordy;
        acc = v && in_ready;
        hs = out_valid && ordy;
        ov0 = out_valid;
        o0 = out;
        @(posedge clk);
        #1;
        cyc++;
        took = acc;
        if (hs) begin
            busy = 1'b0;
            if (exp_q.size() == 0) check("spurious_out", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("out", o0, e);
            end
        end else if (ov0) begin
            check("out_hold", out, o0);
            check("valid_hold", out_valid, 1);
        end
        if (acc) begin
            hist.push_back(d);
            nacc++;
            if (nacc % DEC == 0) begin
                exp_q.push_back(model());
                acc_cyc = cyc;
                busy = 1'b1;
            end
        end
        if (!ov0 && out_valid) check("latency", cyc - acc_cyc, NT + 2);
        check("in_ready", in_ready, !busy);
    endtask

    task automatic feed(input logic signed [DW-1:0] d);
        logic took = 1'b0;
        for (int t = 0; t < 200 && !took; t++) step(1'b1, d, 1'b1, took);
        if (!took) check("feed_timeout", 0, 1);
    endtask

    task automatic drain();
        logic tk;
        for (int t = 0; t < 200 && exp_q.size() > 0; t++) step(1'b0, '0, 1'b1, tk);
        check("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hist.delete();
        exp_q.delete();
        nacc = 0;
        busy = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_ready", in_ready, 1);
    endtask

    initial begin
        logic tk;
        int   seen;
        for (int i = 0; i < NT; i++) coef[i] = (i < 4) ? 5'sd3 : 5'sd0;

        // Reset and idle
        do_reset();
        seen = 0;
        for (int t = 0; t < 100; t++) begin
            step(1'b0, '0, 1'b1, tk);
            if (out_valid) seen++;
        end
        check("idle_valid", seen, 0);

        // Impulse: expect 3, 3, 0
        feed(1); feed(0); feed(0); feed(0); feed(0); feed(0);
        drain();

        // Overflow with a constant input
        do_reset();
        for (int i = 0; i < 8; i++) feed(15);
        drain();

        // Backpressure while an output is pending
        do_reset();
        feed(2); feed(-3);
        for (int t = 0; t < 100 && !out_valid; t++) step(1'b0, '0, 1'b0, tk);
        check("bp_valid", out_valid, 1);
        for (int t = 0; t < 20; t++) step(1'b1, 5'sd7, 1'b0, tk);
        step(1'b0, '0, 1'b1, tk);
        check("bp_ready_after", in_ready, 1);
        check("bp_valid_after", out_valid, 0);

        // Reset in the middle of a MAC pass
        do_reset();
        feed(5); feed(4);
        for (int t = 0; t < 10; t++) step(1'b0, '0, 1'b1, tk);
        do_reset();
        feed(1); feed(0);
        drain();

        // Ramp
        do_reset();
        for (int v = -16; v <= 15; v++) feed(DW'(v));
        drain();

        // Random coefficients, samples and handshakes
        do_reset();
        for (int i = 0; i < NT; i++) coef[i] = CW'($urandom_range(0, 31));
        for (int t = 0; t < 1500; t++)
            step(($urandom % 4) != 0, DW'($urandom_range(0, 31)), ($urandom % 3) != 0, tk);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
